// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing MAC slice.
// Contents: default stream length, product-mode encodings, MAC FSM state
// enum, and width helpers for the accumulator and term index.
package sc_pkg;

    // 128-bit frames, matching the 7-bit SNG counter
    localparam int unsigned SC_LEN_LOG2 = 7;

    // Product mode: AND for unipolar streams, XNOR for bipolar streams
    localparam bit SC_UNIPOLAR = 1'b0;
    localparam bit SC_BIPOLAR  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_e;

    // Bits needed to hold terms * 2^len_log2 without overflow
    function automatic int unsigned sc_acc_width(input int unsigned len_log2,
                                                 input int unsigned terms);
        return len_log2 + 32'd1 + 32'($clog2(terms));
    endfunction

    // Term index width, never below one bit
    function automatic int unsigned sc_idx_width(input int unsigned terms);
        return (terms > 32'd1) ? 32'($clog2(terms)) : 32'd1;
    endfunction

endpackage

// File: rtl/sc_frame_counter.sv
// Bit/term position tracker for one MAC operation.
// Ports: clk, rst (async active-low), clr (sync clear), en (advance by one
// sampled bit), term_cnt (current term), last_c (this sample completes the
// final frame of the final term).
module sc_frame_counter
    import sc_pkg::*;
#(
    parameter int unsigned LEN_LOG2 = SC_LEN_LOG2,
    parameter int unsigned TERMS    = 4,
    parameter int unsigned IDX_W    = sc_idx_width(TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] term_cnt,
    output logic             last_c
);

    localparam logic [LEN_LOG2-1:0] BIT_MAX   = '1;
    localparam logic [IDX_W-1:0]    TERM_LAST = IDX_W'(TERMS - 32'd1);

    logic [LEN_LOG2-1:0] bit_cnt;

    assign last_c = (bit_cnt == BIT_MAX) && (term_cnt == TERM_LAST);

    // Final sample returns both counters to zero so term index reads 0 after completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            term_cnt <= '0;
        end else if (clr) begin
            bit_cnt  <= '0;
            term_cnt <= '0;
        end else if (en) begin
            if (last_c) begin
                bit_cnt  <= '0;
                term_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == BIT_MAX) begin
                    term_cnt <= term_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sc_mac_accum.sv
// Stochastic multiply-accumulate: multiplies two aligned bitstreams bit by
// bit (AND unipolar / XNOR bipolar), counts product ones over TERMS frames of
// 2^LEN_LOG2 sampled bits, and presents the binary count with a 1-cycle pulse.
// Ports: clk, rst (async active-low), start, clear (sync abort), in_en
// (sample qualifier), x_sn/w_sn (streams), busy, term_idx, sum, sum_valid.
module sc_mac_accum
    import sc_pkg::*;
#(
    parameter  int unsigned LEN_LOG2 = SC_LEN_LOG2,
    parameter  int unsigned TERMS    = 4,
    parameter  bit          BIPOLAR  = SC_UNIPOLAR,
    localparam int unsigned ACC_W    = sc_acc_width(LEN_LOG2, TERMS),
    localparam int unsigned IDX_W    = sc_idx_width(TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             in_en,
    input  logic             x_sn,
    input  logic             w_sn,
    output logic             busy,
    output logic [IDX_W-1:0] term_idx,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid
);

    mac_state_e       state;
    mac_state_e       state_nxt;
    logic             cnt_clr;
    logic             smp_en;
    logic             last_c;
    logic             p_c;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum_c;

    // Bit-level product of the two streams
    assign p_c       = (BIPOLAR == SC_BIPOLAR) ? ~(x_sn ^ w_sn) : (x_sn & w_sn);
    assign acc_sum_c = acc + ACC_W'(p_c);

    sc_frame_counter #(
        .LEN_LOG2 (LEN_LOG2),
        .TERMS    (TERMS),
        .IDX_W    (IDX_W)
    ) u_frame_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (smp_en),
        .term_cnt (term_idx),
        .last_c   (last_c)
    );

    // Next state and per-cycle controls; clear overrides everything
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        smp_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    cnt_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_en) begin
                    smp_en = 1'b1;
                    if (last_c) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                if (start) begin
                    state_nxt = ST_RUN;
                    cnt_clr   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
            smp_en    = 1'b0;
        end
    end

    // State, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            sum_valid <= 1'b0;
            acc       <= '0;
            sum       <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt == ST_RUN);
            sum_valid <= (state_nxt == ST_DONE);
            if (cnt_clr) begin
                acc <= '0;
            end else if (smp_en) begin
                acc <= last_c ? '0 : acc_sum_c;
            end
            // Final sample is folded in directly so sum is valid in DONE
            if (smp_en && last_c) begin
                sum <= acc_sum_c;
            end
        end
    end

endmodule

// File: tb/tb_sc_mac_accum.sv
// Scoreboard bench for sc_mac_accum: a unipolar and a bipolar instance share
// the same stimulus; each start pushes the hand-computed sum and the cycle in
// which sum_valid must appear, and a monitor pops on every sum_valid pulse.
module tb_sc_mac_accum;

    localparam int N = 512;  // TERMS * 2^LEN_LOG2

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       in_en = 1'b0;
    logic       x_sn = 1'b0;
    logic       w_sn = 1'b0;
    logic       busy_u, sv_u, busy_b, sv_b;
    logic [1:0] ti_u, ti_b;
    logic [9:0] sum_u, sum_b;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;

    typedef struct {
        int unsigned sum;
        longint      cyc;
    } exp_t;

    exp_t q_u[$];
    exp_t q_b[$];

    sc_mac_accum #(.LEN_LOG2(7), .TERMS(4), .BIPOLAR(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .in_en(in_en),
        .x_sn(x_sn), .w_sn(w_sn), .busy(busy_u), .term_idx(ti_u),
        .sum(sum_u), .sum_valid(sv_u)
    );

    sc_mac_accum #(.LEN_LOG2(7), .TERMS(4), .BIPOLAR(1'b1)) u_dut_bp (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .in_en(in_en),
        .x_sn(x_sn), .w_sn(w_sn), .busy(busy_b), .term_idx(ti_b),
        .sum(sum_b), .sum_valid(sv_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every sum_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst && sv_u) begin
            exp_t e;
            if (q_u.size() == 0) begin
                chk("uni unexpected sum_valid", 1, 0);
            end else begin
                e = q_u.pop_front();
                chk("uni sum", sum_u, e.sum);
                chk("uni valid cycle", cyc, e.cyc);
            end
        end
        if (rst && sv_b) begin
            exp_t e;
            if (q_b.size() == 0) begin
                chk("bip unexpected sum_valid", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("bip sum", sum_b, e.sum);
                chk("bip valid cycle", cyc, e.cyc);
            end
        end
    end

    // 0: constant 0, 1: constant 1, 2: counter SNG with value 64 (first half of frame ones)
    function automatic logic stream(input int mode, input int k);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return ((k % 128) < 64);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            in_en = 1'b0;
        end
    endtask

    // One MAC operation; abort_k >= 0 aborts (clear or reset) after that many samples
    task automatic do_op(input int xm, input int wm, input bit tog,
                         input int eu, input int eb,
                         input int abort_k, input bit abort_rst, input bit start_mid);
        longint s;
        int     k;
        logic   en;
        @(negedge clk);
        s     = cyc;
        start = 1'b1;
        clear = 1'b0;
        in_en = 1'b0;
        if (abort_k < 0) begin
            q_u.push_back(exp_t'{sum: eu, cyc: s + (tog ? 1025 : 513)});
            q_b.push_back(exp_t'{sum: eb, cyc: s + (tog ? 1025 : 513)});
        end
        k = 0;
        while (k < N) begin
            @(negedge clk);
            start = 1'b0;
            if (k % 128 == 5) begin
                chk("busy in run", busy_u, 1);
                chk("term_idx", ti_u, k / 128);
            end
            if (k == abort_k) begin
                in_en = 1'b0;
                if (abort_rst) begin
                    rst = 1'b0;
                    #1;
                    chk("rst busy", busy_u, 0);
                    chk("rst term_idx", ti_u, 0);
                    chk("rst sum uni", sum_u, 0);
                    chk("rst sum bip", sum_b, 0);
                    chk("rst sum_valid", sv_u, 0);
                    @(negedge clk);
                    rst = 1'b1;
                end else begin
                    clear = 1'b1;
                    @(negedge clk);
                    clear = 1'b0;
                    chk("clear busy", busy_u, 0);
                    chk("clear term_idx", ti_u, 0);
                    chk("clear keeps sum uni", sum_u, 512);
                    chk("clear keeps sum bip", sum_b, 512);
                    chk("clear no sum_valid", sv_u, 0);
                end
                return;
            end
            en    = tog ? ((cyc - s) % 2 == 0) : 1'b1;
            x_sn  = stream(xm, k);
            w_sn  = stream(wm, k);
            in_en = en;
            start = start_mid && (k == 50);
            if (en) k++;
        end
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset busy", busy_u, 0);
        chk("reset term_idx", ti_u, 0);
        chk("reset sum", sum_u, 0);
        chk("reset sum_valid", sv_u, 0);
        chk("reset sum bip", sum_b, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        do_op(2, 1, 1'b0, 256, 256, -1, 1'b0, 1'b0); idle(3);  // SNG(64) x 1
        do_op(1, 1, 1'b0, 512, 512, -1, 1'b0, 1'b0); idle(3);  // full scale
        do_op(0, 1, 1'b0,   0,   0, -1, 1'b0, 1'b0); idle(3);
        do_op(0, 0, 1'b0,   0, 512, -1, 1'b0, 1'b0); idle(3);  // XNOR(0,0)=1
        do_op(1, 0, 1'b0,   0,   0, -1, 1'b0, 1'b0); idle(3);
        do_op(1, 1, 1'b1, 512, 512, -1, 1'b0, 1'b0); idle(3);  // in_en toggling
        do_op(1, 1, 1'b0,   0,   0, 300, 1'b0, 1'b0); idle(5); // clear mid-run
        do_op(0, 1, 1'b0,   0,   0, -1, 1'b0, 1'b0); idle(3);
        do_op(1, 1, 1'b0, 512, 512, -1, 1'b0, 1'b0);           // next start lands in DONE
        do_op(0, 0, 1'b0,   0, 512, -1, 1'b0, 1'b0); idle(3);
        do_op(1, 1, 1'b0, 512, 512, -1, 1'b0, 1'b1); idle(3);  // start during RUN ignored
        do_op(1, 1, 1'b0,   0,   0, 100, 1'b1, 1'b0); idle(3); // reset mid-run
        do_op(2, 0, 1'b0,   0, 256, -1, 1'b0, 1'b0); idle(3);

        for (int i = 0; i < 2000 && (q_u.size() != 0 || q_b.size() != 0); i++) begin
            @(negedge clk);
        end
        chk("uni results outstanding", q_u.size(), 0);
        chk("bip results outstanding", q_b.size(), 0);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
